// File: rtl/bidir_ram_fill.sv
// Single-port RAM on a shared bidirectional data bus. Reads are registered
// and flagged by rd_valid; a fill engine writes one word per cycle across the array.
module bidir_ram_fill #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          ADDR_W    = 4,
  parameter logic [DATA_W-1:0]    RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              rd_valid,
  output logic              err
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W-1:0]   ptr_s;
  logic [DATA_W-1:0]   pattern_r;
  logic [DATA_W-1:0]   pattern_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   rdata_r;
  logic                rd_valid_r;
  logic                err_r;
  logic                busy_r;

  logic                we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [DATA_W-1:0]   wdata_s;
  logic                rd_en_s;
  logic                err_s;
  logic                drive_s;

  // Next-state, memory write port and request arbitration.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    pattern_s = pattern_r;
    we_s      = 1'b0;
    waddr_s   = address;
    wdata_s   = data;
    rd_en_s   = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (fill) begin
          state_s   = FILL;
          ptr_s     = PTR_ZERO;
          pattern_s = fill_data;
          err_s     = read | write;
        end else if (read && write) begin
          err_s = 1'b1;
        end else if (write) begin
          we_s = 1'b1;
        end else if (read) begin
          rd_en_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      FILL: begin
        // Master requests are rejected while the sweep owns the write port.
        we_s    = 1'b1;
        waddr_s = ptr_r;
        wdata_s = pattern_r;
        err_s   = read | write;
        ptr_s   = ptr_r + PTR_STEP;
        if (ptr_r == LAST_ADDR) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      default: begin
        state_s = IDLE;
        ptr_s   = PTR_ZERO;
      end
    endcase
  end

  // Control registers and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      ptr_r      <= PTR_ZERO;
      pattern_r  <= {DATA_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      pattern_r  <= pattern_s;
      rd_valid_r <= rd_en_s;
      err_r      <= err_s;
      busy_r     <= (state_s == FILL);
      if (rd_en_s) begin
        rdata_r <= mem_r[address];
      end
    end
  end

  // Storage array; reset clears every word so an aborted fill leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_VAL;
      end
    end else if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // A write raised during a response cycle releases the bus at once.
  assign drive_s  = rd_valid_r & ~write;
  assign data     = drive_s ? rdata_r : {DATA_W{1'bz}};
  assign busy     = busy_r;
  assign rd_valid = rd_valid_r;
  assign err      = err_r;

endmodule

// File: tb/tb_bidir_ram_fill.sv
// Randomised and directed bench for bidir_ram_fill, checked against a
// word-level reference model of the RAM and its fill sweep.
module tb_bidir_ram_fill;

  localparam int         DEPTH = 16;
  localparam logic [7:0] RV    = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] data;
  logic [3:0] address;
  logic       read;
  logic       write;
  logic       fill;
  logic [7:0] fill_data;
  logic       busy;
  logic       rd_valid;
  logic       err;

  // The master parks a probe value whenever the RAM must not drive, so any
  // stray drive from the RAM corrupts what is seen on the bus.
  assign data = drv_en ? drv : 8'hzz;

  always #5 clk = ~clk;

  bidir_ram_fill #(.DATA_W(8), .ADDR_W(4), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .data(data), .address(address),
    .read(read), .write(write), .fill(fill), .fill_data(fill_data),
    .busy(busy), .rd_valid(rd_valid), .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [DEPTH];
  int         fill_left;
  logic [7:0] pat_m;
  logic [7:0] exp_rd;
  logic       exp_rv;
  logic       exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = RV;
    fill_left = 0;
    pat_m     = 8'h00;
    exp_rd    = 8'h00;
    exp_rv    = 1'b0;
    exp_err   = 1'b0;
  endtask

  // One clock edge of the RAM as described in words: fill sweep first, then requests.
  task automatic model_edge(input logic rd, input logic wr, input logic fl,
                            input logic [3:0] addr, input logic [7:0] din, input logic [7:0] fd);
    exp_rv = 1'b0;
    if (fill_left > 0) begin
      mem_m[DEPTH - fill_left] = pat_m;
      fill_left = fill_left - 1;
      exp_err = rd | wr;
    end else if (fl) begin
      pat_m = fd;
      fill_left = DEPTH;
      exp_err = rd | wr;
    end else if (rd && wr) begin
      exp_err = 1'b1;
    end else if (wr) begin
      mem_m[addr] = din;
      exp_err = 1'b0;
    end else if (rd) begin
      exp_rd = mem_m[addr];
      exp_rv = 1'b1;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
    end
  endtask

  // Called at a falling edge: apply inputs, check outputs of the previous edge, clock once.
  task automatic cyc(input logic rd, input logic wr, input logic fl,
                     input logic [3:0] addr, input logic [7:0] din, input logic [7:0] fd);
    logic [7:0] probe;
    logic [7:0] exp_bus;
    read = rd; write = wr; fill = fl; address = addr; fill_data = fd;
    probe = 8'($urandom);
    if (wr) begin
      drv_en = 1'b1; drv = din; exp_bus = din;
    end else if (exp_rv) begin
      drv_en = 1'b0; drv = probe; exp_bus = exp_rd;
    end else begin
      drv_en = 1'b1; drv = probe; exp_bus = probe;
    end
    #1;
    check_eq("busy", 32'(busy), 32'(fill_left > 0));
    check_eq("rd_valid", 32'(rd_valid), 32'(exp_rv));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("data", 32'(data), 32'(exp_bus));
    @(posedge clk);
    model_edge(rd, wr, fl, addr, din, fd);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase.
  task automatic do_reset();
    read = 1'b0; write = 1'b0; fill = 1'b0;
    drv_en = 1'b1; drv = 8'($urandom);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_data", 32'(data), 32'(drv));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; fill = 1'b0;
    address = 4'h0; fill_data = 8'h00; drv = 8'h00; drv_en = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Every word holds the reset value.
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, 1'b0, 1'b0, 4'(a), 8'h00, 8'h00);
    idle();

    // Write then read-after-write, plus neighbours.
    cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd2, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd4, 8'h00, 8'h00);
    idle();

    // Full fill with a read rejected in busy cycle 5.
    cyc(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'h3C);
    for (int i = 0; i < DEPTH; i++) cyc(i == 4, 1'b0, 1'b0, 4'd9, 8'h00, 8'($urandom));
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, 1'b0, 1'b0, 4'(a), 8'h00, 8'h00);
    idle();

    // Collision at address 7 leaves memory untouched.
    cyc(1'b1, 1'b1, 1'b0, 4'd7, 8'hFF, 8'h00);
    idle();
    cyc(1'b1, 1'b0, 1'b0, 4'd7, 8'h00, 8'h00);
    idle();

    // Reset during busy cycle 8 of a fill wipes the partial pattern.
    cyc(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'hFF);
    for (int i = 0; i < 7; i++) idle();
    do_reset();
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, 1'b0, 1'b0, 4'(a), 8'h00, 8'h00);
    idle();

    // Back-to-back reads, then a write that lands in a response cycle.
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 8'h11, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 4'd1, 8'h22, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 4'd2, 8'h33, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd2, 8'h00, 8'h00);
    idle();
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 8'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 4'd5, 8'h77, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 8'h00, 8'h00);
    idle();

    // Random traffic with occasional fills and resets.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, r < 6,
            4'($urandom), 8'($urandom), 8'($urandom));
      end
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
